// File: rtl/pitch_pkg.sv
// Shared defaults, FSM state encoding and sample type for the pitch resampler.
package pitch_pkg;

  localparam int ADDR_W_DEF = 23;
  localparam int CH_DEF     = 2;
  localparam int STEP_W_DEF = 8;
  localparam int FRAC_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    RD_A,
    RD_B,
    MIX,
    WR,
    FIN
  } state_t;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/pitch_lerp.sv
// One-channel linear interpolation: y = a + floor((b - a) * frac / 2^FRAC_W).
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module pitch_lerp
  import pitch_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic [15:0]       a,
  input  logic [15:0]       b,
  input  logic [FRAC_W-1:0] frac,
  output logic [15:0]       y
);

  localparam int PW = 17 + FRAC_W + 1;

  sample_t              sa;
  sample_t              sb;
  logic signed [16:0]   diff;
  logic signed [FRAC_W:0] fs;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic signed [PW-1:0] sum;

  // The difference needs 17 bits so full-scale swings do not overflow.
  always_comb begin
    sa      = sample_t'(a);
    sb      = sample_t'(b);
    diff    = {sb[15], sb} - {sa[15], sa};
    fs      = {1'b0, frac};
    prod    = PW'(diff) * PW'(fs);
    shifted = prod >>> FRAC_W;
    sum     = PW'(sa) + shifted;
    y       = sum[15:0];
  end

endmodule

// File: rtl/pitch_resampler.sv
// Resamples a packed multi-channel sample stream between SDRAM buffers at a fixed-point step.
// Latency: start -> CALC next cycle -> first read strobe the cycle after; one word per output.
// Backpressure: each strobe is held with stable address/data until i_finished.
module pitch_resampler
  import pitch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CH     = CH_DEF,
  parameter int STEP_W = STEP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [ADDR_W-1:0] i_dst_addr,
  input  logic [ADDR_W-1:0] i_length,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_interp,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_read,
  output logic              o_write,
  output logic [ADDR_W-1:0] o_addr,
  input  logic [16*CH-1:0]  i_readdata,
  output logic [16*CH-1:0]  o_writedata,
  input  logic              i_finished
);

  localparam int DATA_W = 16 * CH;
  localparam int POS_W  = ADDR_W + FRAC_W + 1;
  localparam int IDX_W  = ADDR_W + 1;

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] len;
  logic [STEP_W-1:0] step;
  logic              interp;
  logic [POS_W-1:0]  pos;
  logic [ADDR_W-1:0] count;

  logic [IDX_W-1:0]  tag  [2];
  logic [DATA_W-1:0] cdat [2];
  logic [1:0]        cval;
  logic              victim;

  logic [DATA_W-1:0] word_a;
  logic [DATA_W-1:0] word_b;
  logic              use_b;
  logic              rd_b_pend;

  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx1;
  logic [FRAC_W-1:0] frac;
  logic              past_end;
  logic              need_b;
  logic              hit_a0, hit_a1, hit_b0, hit_b1;
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] dat_a, dat_b;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [POS_W:0]    pos_sum;
  logic [POS_W-1:0]  pos_next;
  logic [DATA_W-1:0] mix_b;
  logic [DATA_W-1:0] mix_y;

  always_comb begin
    idx      = pos[POS_W-1:FRAC_W];
    frac     = pos[FRAC_W-1:0];
    idx1     = idx + IDX_W'(1);
    past_end = idx >= {1'b0, len};
    // When A is the last source word, B falls back to A and is never fetched.
    need_b   = interp && (frac != '0) && (idx1 != {1'b0, len});
    hit_a0   = cval[0] && (tag[0] == idx);
    hit_a1   = cval[1] && (tag[1] == idx);
    hit_b0   = cval[0] && (tag[0] == idx1);
    hit_b1   = cval[1] && (tag[1] == idx1);
    hit_a    = hit_a0 || hit_a1;
    hit_b    = hit_b0 || hit_b1;
    dat_a    = hit_a0 ? cdat[0] : cdat[1];
    dat_b    = hit_b0 ? cdat[0] : cdat[1];
    addr_a   = src + idx[ADDR_W-1:0];
    addr_b   = src + idx1[ADDR_W-1:0];
    pos_sum  = {1'b0, pos} + (POS_W+1)'(step);
    pos_next = pos_sum[POS_W] ? '1 : pos_sum[POS_W-1:0];
    mix_b    = use_b ? word_b : word_a;
  end

  for (genvar k = 0; k < CH; k++) begin : g_lerp
    pitch_lerp #(.FRAC_W(FRAC_W)) u_lerp (
      .a    (word_a[16*k +: 16]),
      .b    (mix_b[16*k +: 16]),
      .frac (frac),
      .y    (mix_y[16*k +: 16])
    );
  end

  assign o_count = count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_read      <= 1'b0;
      o_write     <= 1'b0;
      o_addr      <= '0;
      o_writedata <= '0;
      count       <= '0;
      pos         <= '0;
      cval        <= '0;
      victim      <= 1'b0;
      use_b       <= 1'b0;
      rd_b_pend   <= 1'b0;
      src         <= '0;
      dst         <= '0;
      len         <= '0;
      step        <= '0;
      interp      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            src    <= i_src_addr;
            dst    <= i_dst_addr;
            len    <= i_length;
            step   <= i_step;
            interp <= i_interp;
            pos    <= '0;
            count  <= '0;
            cval   <= '0;
            victim <= 1'b0;
            o_busy <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (past_end || (step == '0)) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= FIN;
          end else begin
            use_b     <= need_b;
            rd_b_pend <= need_b && !hit_b;
            word_a    <= dat_a;
            word_b    <= dat_b;
            if (!hit_a) begin
              o_read <= 1'b1;
              o_addr <= addr_a;
              state  <= RD_A;
            end else if (need_b && !hit_b) begin
              o_read <= 1'b1;
              o_addr <= addr_b;
              state  <= RD_B;
            end else begin
              state <= MIX;
            end
          end
        end
        RD_A: begin
          if (o_read && i_finished) begin
            o_read       <= 1'b0;
            word_a       <= i_readdata;
            tag[victim]  <= idx;
            cdat[victim] <= i_readdata;
            cval[victim] <= 1'b1;
            victim       <= ~victim;
            state        <= rd_b_pend ? RD_B : MIX;
          end
        end
        RD_B: begin
          // Entered from RD_A with the strobe low: raise it a cycle later.
          if (!o_read) begin
            o_read <= 1'b1;
            o_addr <= addr_b;
          end else if (i_finished) begin
            o_read       <= 1'b0;
            word_b       <= i_readdata;
            tag[victim]  <= idx1;
            cdat[victim] <= i_readdata;
            cval[victim] <= 1'b1;
            victim       <= ~victim;
            state        <= MIX;
          end
        end
        MIX: begin
          o_writedata <= mix_y;
          o_write     <= 1'b1;
          o_addr      <= dst + count;
          state       <= WR;
        end
        WR: begin
          if (i_finished) begin
            o_write <= 1'b0;
            count   <= count + ADDR_W'(1);
            pos     <= pos_next;
            state   <= CALC;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_resampler.sv
// Scoreboard bench for pitch_resampler: directed jobs against a small SDRAM responder.
module tb_pitch_resampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [22:0] src, dst, len, cnt, addr;
  logic [7:0]  step;
  logic        interp;
  logic        rd, wr, fin;
  logic [31:0] rdata, wdata;

  always #5 clk = ~clk;

  pitch_resampler dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .i_src_addr(src), .i_dst_addr(dst), .i_length(len), .i_step(step),
    .i_interp(interp), .o_count(cnt), .o_read(rd), .o_write(wr), .o_addr(addr),
    .i_readdata(rdata), .o_writedata(wdata), .i_finished(fin)
  );

  typedef struct packed { logic [22:0] addr; logic [31:0] data; } wr_t;
  typedef struct packed { logic [22:0] count; logic [31:0] reads; } job_t;

  wr_t         exp_w[$];
  job_t        exp_j[$];
  logic [31:0] mem [256];
  int          checks = 0, errors = 0, done_cnt = 0, reads_seen = 0;
  bit          hold_fin = 0, force_fin = 0;
  int          lat = 0, wait_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SDRAM responder: finishes each strobe after a rotating 0..2 cycle wait.
  initial begin
    fin   = 1'b0;
    rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (force_fin) begin
        fin = 1'b1;
      end else if ((rd || wr) && !hold_fin && !fin) begin
        if (wait_cnt >= lat) begin
          fin      = 1'b1;
          rdata    = mem[addr[7:0]];
          wait_cnt = 0;
          lat      = (lat + 1) % 3;
        end else begin
          wait_cnt++;
        end
      end else begin
        fin      = 1'b0;
        rdata    = 32'hDEAD_BEEF;
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops expected writes and job results as the DUT presents them.
  initial begin : monitor
    logic        prev_strobe;
    logic        prev_fin;
    logic [22:0] prev_addr;
    wr_t         ew;
    job_t        ej;
    prev_strobe = 1'b0;
    prev_fin    = 1'b0;
    prev_addr   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) reads_seen = 0;
      if (rd && wr) check("rd_wr_exclusive", {rd, wr}, 2'b01);
      if (prev_strobe && !prev_fin && (rd || wr)) check("addr_stable", addr, prev_addr);
      if (rd && fin) reads_seen++;
      if (wr && fin) begin
        if (exp_w.size() == 0) begin
          check("unexpected_write", addr, 23'h7FFFFF ^ addr);
        end else begin
          ew = exp_w.pop_front();
          check("wr_addr", addr, ew.addr);
          check("wr_data", wdata, ew.data);
        end
      end
      if (done) begin
        if (exp_j.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          ej = exp_j.pop_front();
          check("done_count", cnt, ej.count);
          check("done_reads", reads_seen, ej.reads);
          check("done_busy_low", busy, 1'b0);
        end
        reads_seen = 0;
        done_cnt++;
      end
      prev_strobe = rd || wr;
      prev_fin    = fin;
      prev_addr   = addr;
    end
  end

  task automatic push_w(input logic [22:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_w.push_back(w);
  endtask

  task automatic push_j(input logic [22:0] c, input logic [31:0] r);
    job_t j;
    j.count = c;
    j.reads = r;
    exp_j.push_back(j);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) @(negedge clk);
    check("done_timeout", done_cnt, target);
  endtask

  task automatic run_job(input logic [22:0] s, input logic [22:0] d, input logic [22:0] l,
                         input logic [7:0] st, input logic ip, input bit chk_lat, input bit poke);
    int target;
    @(negedge clk);
    src = s; dst = d; len = l; step = st; interp = ip; start = 1'b1;
    target = done_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      #1;
      check("first_read_cycle2", rd, 1'b1);
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      step = 8'h00; len = 23'd0; dst = 23'h70; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(target);
  endtask

  initial begin
    int target;
    rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0; step = '0; interp = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h5555_0000 + 32'(i);
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = 32'(i + 1);
    for (int i = 0; i < 5; i++) mem[8'h20 + i] = 32'h2000_0000 + 32'(i) * 32'h11;
    mem[8'h30] = 32'h0000_0000;
    mem[8'h31] = 32'hFF9C_0064;
    mem[8'h38] = 32'h0010_0000;
    mem[8'h39] = 32'h0020_FFFF;
    mem[8'h3A] = 32'h8000_7FFF;
    mem[8'hFE] = 32'hAAAA_0001;
    mem[8'hFF] = 32'hBBBB_0002;
    mem[8'h00] = 32'hCCCC_0003;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_strobes", {rd, wr}, 2'b00);
    check("rst_addr", addr, 23'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_count", cnt, 23'd0);
    rst = 1'b0;

    // Nearest, step 1.0: straight copy.
    for (int i = 0; i < 4; i++) push_w(23'h40 + 23'(i), 32'(i + 1));
    push_j(23'd4, 32'd4);
    run_job(23'h10, 23'h40, 23'd4, 8'h10, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    check("count_holds", cnt, 23'd4);

    // Step 2.0: every other word.
    push_w(23'h50, 32'h2000_0000);
    push_w(23'h51, 32'h2000_0022);
    push_w(23'h52, 32'h2000_0044);
    push_j(23'd3, 32'd3);
    run_job(23'h20, 23'h50, 23'd5, 8'h20, 1'b0, 1'b0, 1'b0);

    // Step 0.5 interpolation over two words; second pass hits the cache.
    push_w(23'h60, 32'h0000_0000);
    push_w(23'h61, 32'hFFCE_0032);
    push_w(23'h62, 32'hFF9C_0064);
    push_w(23'h63, 32'hFF9C_0064);
    push_j(23'd4, 32'd2);
    run_job(23'h30, 23'h60, 23'd2, 8'h08, 1'b1, 1'b0, 1'b0);

    // Floor rounding of negative halves and full-scale differences.
    push_w(23'h68, 32'h0010_0000);
    push_w(23'h69, 32'h0018_FFFF);
    push_w(23'h6A, 32'h0020_FFFF);
    push_w(23'h6B, 32'hC010_3FFF);
    push_w(23'h6C, 32'h8000_7FFF);
    push_w(23'h6D, 32'h8000_7FFF);
    push_j(23'd6, 32'd3);
    run_job(23'h38, 23'h68, 23'd3, 8'h08, 1'b1, 1'b0, 1'b0);

    // Zero step completes on the second cycle after the start request.
    push_j(23'd0, 32'd0);
    @(negedge clk);
    src = 23'h10; dst = 23'h40; len = 23'd4; step = 8'h00; interp = 1'b0; start = 1'b1;
    target = done_cnt + 1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("step0_no_done_cycle1", done, 1'b0);
    @(negedge clk);
    #1;
    check("step0_done_cycle2", done, 1'b1);
    check("step0_no_access", {rd, wr}, 2'b00);
    wait_done(target);

    // Zero length.
    push_j(23'd0, 32'd0);
    run_job(23'h10, 23'h40, 23'd0, 8'h10, 1'b0, 1'b0, 1'b0);

    // Start pulse while busy must not disturb the running job.
    for (int i = 0; i < 4; i++) push_w(23'h48 + 23'(i), 32'(i + 1));
    push_j(23'd4, 32'd4);
    run_job(23'h10, 23'h48, 23'd4, 8'h10, 1'b0, 1'b0, 1'b1);

    // Source and destination addresses wrap at the top of the address space.
    push_w(23'h7FFFFF, 32'hAAAA_0001);
    push_w(23'h000000, 32'hBBBB_0002);
    push_w(23'h000001, 32'hCCCC_0003);
    push_j(23'd3, 32'd3);
    run_job(23'h7FFFFE, 23'h7FFFFF, 23'd3, 8'h10, 1'b0, 1'b0, 1'b0);

    // Reset while a read is held, then a stray i_finished in IDLE.
    hold_fin = 1'b1;
    @(negedge clk);
    src = 23'h10; dst = 23'h40; len = 23'd4; step = 8'h10; interp = 1'b0; start = 1'b1;
    target = done_cnt;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !rd; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    #1;
    check("rst_mid_read_held", rd, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_read", rd, 1'b0);
    check("rst_mid_write", wr, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    check("rst_mid_addr", addr, 23'd0);
    check("rst_mid_count", cnt, 23'd0);
    hold_fin = 1'b0;
    @(posedge clk);
    #1 force_fin = 1'b1;
    @(posedge clk);
    #1 force_fin = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_ignores_finished", {busy, rd, wr}, 3'b000);
    check("rst_no_done", done_cnt, target);

    push_w(23'h58, 32'h2000_0000);
    push_w(23'h59, 32'h2000_0022);
    push_w(23'h5A, 32'h2000_0044);
    push_j(23'd3, 32'd3);
    run_job(23'h20, 23'h58, 23'd5, 8'h20, 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("leftover_writes", exp_w.size(), 0);
    check("leftover_jobs", exp_j.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pitch_resampler.md
PITCH_RESAMPLER -- requirements
Module: pitch_resampler

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, SDRAM word address width.
REQ-002 SHALL have parameter CH, default 2, 16-bit signed channels packed per word; DATA_W = 16*CH; channel k in bits [16k+15:16k].
REQ-003 SHALL have parameter STEP_W, default 8, width of i_step.
REQ-004 SHALL have parameter FRAC_W, default 4, fractional bits of i_step; i_step is unsigned fixed point.
REQ-005 SHALL use one clock; reset is synchronous and active-high: i_clk input 1 (all logic on rising edge); i_rst input 1.
REQ-006 SHALL have i_start input 1, one-cycle job request; o_busy output 1, job active; o_done output 1, one-cycle completion pulse.
REQ-007 SHALL have i_src_addr and i_dst_addr inputs ADDR_W (source/destination base); i_length input ADDR_W (source word count); i_step input STEP_W (read increment per output word).
REQ-008 SHALL have i_interp input 1 (0 nearest/truncate, 1 linear interpolation); o_count output ADDR_W (words written in current/last job).
REQ-009 SHALL have SDRAM port: o_read output 1; o_write output 1; o_addr output ADDR_W; i_readdata input DATA_W; o_writedata output DATA_W; i_finished input 1 (access complete).

Function
REQ-010 SHALL latch all job inputs when i_start=1 in IDLE; i_start while o_busy=1 SHALL be ignored.
REQ-011 SHALL keep phase pos, width ADDR_W+FRAC_W+1, cleared at start; idx = pos>>FRAC_W, frac = pos[FRAC_W-1:0]; pos += i_step after each write; pos SHALL not wrap.
REQ-012 SHALL use states IDLE, CALC, RD_A, RD_B, MIX, WR, FIN.
REQ-013 CALC SHALL go to FIN if idx >= length, else RD_A (or MIX on cache hit, REQ-017).
REQ-014 SHALL hold o_read or o_write high with o_addr/o_writedata stable until the cycle i_finished=1; i_readdata sampled in that cycle; strobe deasserts next cycle; never read and write together.
REQ-015 SHALL read word A at src+idx; B at src+idx+1 only if i_interp=1 and frac!=0; if idx+1 == length, B = A with no read.
REQ-016 SHALL compute per channel y = a + ((b-a)*frac >>> FRAC_W), 17-bit signed difference, arithmetic (floor) shift, result 16 bits; nearest mode or frac=0 gives y = a.
REQ-017 SHALL hold a two-entry word cache tagged by source index; a needed word whose tag matches either entry SHALL be used without an SDRAM read; cache invalidated at start.
REQ-018 SHALL register the MIX result; WR SHALL write it to dst+count; count increments on write i_finished; o_count = count.
REQ-019 FIN SHALL pulse o_done for one cycle, clear o_busy, then return to IDLE; o_count holds until next start.
REQ-020 i_length=0 or i_step=0 SHALL go straight to FIN with no SDRAM access, o_count=0.
REQ-021 address sums SHALL wrap modulo 2^ADDR_W.
REQ-022 latency: i_start at cycle 0 -> CALC cycle 1 -> first o_read cycle 2.

Reset
REQ-023 i_rst=1 at any edge SHALL force IDLE, o_read=o_write=o_busy=o_done=0, o_addr=0, o_writedata=0, o_count=0, cache invalid, pos=0.
REQ-024 reset mid-access SHALL drop the strobe at that edge without o_done; a later i_finished in IDLE SHALL be ignored.

Structure
REQ-025 pitch_pkg SHALL hold default parameters, the state enum, and a 16-bit signed sample typedef.
REQ-026 SHALL instantiate CH copies of sub-module pitch_lerp (combinational per-channel interpolation of REQ-016).

Verification
REQ-027 step=0x10, nearest, length=4, src words 1,2,3,4 -> 4 reads, 4 writes to dst..dst+3 of 1,2,3,4, o_count=4, one o_done.
REQ-028 step=0x20, length=5 -> reads/writes of idx 0,2,4 only, o_count=3.
REQ-029 step=0x08, interp, length=2, ch0 0/100, ch1 0/-100 -> outputs ch0 0,50,100,100, ch1 0,-50,-100,-100; exactly 2 reads (cache hits).
REQ-030 interp, a=0, b=-1 (ch0), frac=8 -> ch0 -1 (floor).
REQ-031 step=0 -> o_done at cycle 2, no o_read/o_write, o_count=0; i_start while busy -> no effect.
REQ-032 i_rst during held o_read -> next cycle all outputs 0, no o_done; new job then completes normally.
